// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the single-port Tetris board RAM between the
// VGA renderer, the board-clear sequencer (built when BOARD_CLEAR_EN is
// defined) and the game engine. Fixed priority: renderer > clear > game.
module board_mem_arbiter #(
   parameter int CELLS  = 200,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   input  logic              g_req,
   input  logic              g_we,
   input  logic [ADDR_W-1:0] g_addr,
   input  logic [DATA_W-1:0] g_wdata,
   output logic              g_ack,
   output logic [DATA_W-1:0] g_rdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

   logic              rd_hit;
   logic              g_hit;
   logic              g_issue;
   logic              clr_active;
   logic              clr_write;
   logic [ADDR_W-1:0] clr_addr;

   logic              rd_v_q;
   logic              rd_hit_q;
   logic              g_inflight;
   logic              g_we_q;
   logic              g_hit_q;
   logic [DATA_W-1:0] g_rdata_q;
   logic [DATA_W-1:0] g_rd_now;

   assign rd_hit = (rd_addr <= LAST);
   assign g_hit  = (g_addr <= LAST);

`ifdef BOARD_CLEAR_EN
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   clr_state_t        state;
   clr_state_t        state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_nxt;

   // Clear sequencer state and address counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: step the counter on every cycle the renderer leaves free.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (clr_start) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            if (!rd_valid) begin
               cnt_nxt = cnt + ADDR_W'(1);
               if (cnt == LAST) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign clr_active = (state == CLEAR);
   assign clr_write  = clr_active && !rd_valid && !reset;
   assign clr_addr   = cnt;
`else
   logic unused_clr_start;

   assign unused_clr_start = clr_start;
   assign clr_active       = 1'b0;
   assign clr_write        = 1'b0;
   assign clr_addr         = '0;
`endif

   // A game access waits for a slot free of renderer, clear and its own ack.
   assign g_issue = !reset && g_req && !rd_valid &&
                    !clr_active && !g_inflight;

   assign g_rd_now = g_hit_q ? mem_rdata : '0;

   // Pipeline flags for renderer returns and the game in-flight access.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_v_q     <= 1'b0;
         rd_hit_q   <= 1'b0;
         g_inflight <= 1'b0;
         g_we_q     <= 1'b0;
         g_hit_q    <= 1'b0;
         g_rdata_q  <= '0;
      end else begin
         rd_v_q     <= rd_valid;
         rd_hit_q   <= rd_hit;
         g_inflight <= g_issue;
         if (g_issue) begin
            g_we_q  <= g_we;
            g_hit_q <= g_hit;
         end
         if (g_inflight && !g_we_q) begin
            g_rdata_q <= g_rd_now;
         end
      end
   end

   assign rd_data_valid = rd_v_q && !reset;
   assign rd_data       = (rd_v_q && rd_hit_q && !reset) ? mem_rdata : '0;
   assign g_ack         = g_inflight && !reset;
   assign g_rdata       = reset ? '0 :
                          (g_ack && !g_we_q) ? g_rd_now : g_rdata_q;
   assign clr_busy      = clr_active && !reset;

   // RAM port mux; out-of-range requests take their slot without a RAM access.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!reset) begin
         if (rd_valid) begin
            if (rd_hit) begin
               mem_en   = 1'b1;
               mem_addr = rd_addr;
            end
         end else if (clr_write) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = clr_addr;
         end else if (g_issue && g_hit) begin
            mem_en    = 1'b1;
            mem_we    = g_we;
            mem_addr  = g_addr;
            mem_wdata = g_we ? g_wdata : '0;
         end
      end
   end

endmodule
